// File: rtl/demux_1_8_collector.sv
// demux_1_8_collector: serial-to-parallel 1:8 collector.
// Each accepted bit lands in one of eight assembly slots, picked by an internal
// counter (auto mode) or by sel_ext (addressed mode). Once all eight slots are
// filled, the word moves to a single-entry output register with a valid/ready
// handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        serial data bit
//   din_valid  din (and sel_ext in addressed mode) valid this cycle
//   din_ready  collector accepts a bit this cycle (combinational)
//   addr_mode  0 = auto slot counter, 1 = slot from sel_ext
//   sel_ext    external slot address (addressed mode only)
//   sel_cur    current auto slot counter
//   q          assembled word, q[i] = bit written to slot i
//   q_valid    q holds an unconsumed word
//   q_ready    downstream takes q this cycle
module demux_1_8_collector (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       addr_mode,
  input  logic [2:0] sel_ext,
  output logic [2:0] sel_cur,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready
);

  localparam int unsigned NSLOT = 8;
  localparam int unsigned SEL_W = 3;

  // Registered state
  logic [NSLOT-1:0] asm_r;
  logic [NSLOT-1:0] fill_r;
  logic [SEL_W-1:0] cnt_r;
  logic             mode_r;
  logic [NSLOT-1:0] q_r;
  logic             q_valid_r;

  // Next-state values
  logic [NSLOT-1:0] asm_d;
  logic [NSLOT-1:0] fill_d;
  logic [SEL_W-1:0] cnt_d;
  logic [NSLOT-1:0] q_d;
  logic             q_valid_d;

  // Per-cycle decode
  logic [SEL_W-1:0] slot;
  logic [NSLOT-1:0] slot_oh;
  logic [NSLOT-1:0] asm_merged;
  logic             mode_chg;
  logic             would_complete;
  logic             acc;
  logic             complete;

  // Slot selection, handshake and completion detection
  always_comb begin
    slot           = addr_mode ? sel_ext : cnt_r;
    slot_oh        = NSLOT'(1) << slot;
    mode_chg       = (addr_mode != mode_r);
    would_complete = ((fill_r | slot_oh) == {NSLOT{1'b1}});
    // Only the bit that would complete a word stalls on a held output;
    // a mode change swallows whatever is presented that cycle.
    din_ready      = ~mode_chg & ~(q_valid_r & ~q_ready & would_complete);
    acc            = din_valid & din_ready;
    complete       = acc & would_complete;
    asm_merged     = din ? (asm_r | slot_oh) : (asm_r & ~slot_oh);
  end

  // Next-state logic
  always_comb begin
    asm_d     = asm_r;
    fill_d    = fill_r;
    cnt_d     = cnt_r;
    q_d       = q_r;
    q_valid_d = q_valid_r;

    if (mode_chg) begin
      asm_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (complete) begin
      q_d    = asm_merged;
      asm_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (acc) begin
      // Overwrites of an already-filled slot leave fill unchanged.
      asm_d  = asm_merged;
      fill_d = fill_r | slot_oh;
      if (!addr_mode) begin
        cnt_d = cnt_r + SEL_W'(1);
      end
    end

    // A completing bit in the same cycle as a consume reloads without a bubble.
    if (complete) begin
      q_valid_d = 1'b1;
    end else if (q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r     <= '0;
      fill_r    <= '0;
      cnt_r     <= '0;
      mode_r    <= 1'b0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      asm_r     <= asm_d;
      fill_r    <= fill_d;
      cnt_r     <= cnt_d;
      mode_r    <= addr_mode;
      q_r       <= q_d;
      q_valid_r <= q_valid_d;
    end
  end

  assign sel_cur = cnt_r;
  assign q       = q_r;
  assign q_valid = q_valid_r;

endmodule

// File: tb/tb_demux_1_8_collector.sv
// Directed bench for demux_1_8_collector. Expected words go into a scoreboard
// queue as stimulus is driven; a negedge monitor pops and compares each word
// the DUT hands off (q_valid & q_ready).
module tb_demux_1_8_collector;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       addr_mode;
  logic [2:0] sel_ext;
  logic [2:0] sel_cur;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  demux_1_8_collector dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .addr_mode (addr_mode),
    .sel_ext   (sel_ext),
    .sel_cur   (sel_cur),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit for one cycle; it must be accepted.
  task automatic send(input logic b, input logic [2:0] s);
    din       = b;
    sel_ext   = s;
    din_valid = 1'b1;
    @(negedge clk);
    chk("din_ready_send", 8'(din_ready), 8'h01);
    tick();
    din_valid = 1'b0;
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && q_valid && q_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed=%0h expected=none", q);
      end else begin
        chk("q_word", q, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] w;
    logic       b;

    rst = 1'b1; din = 1'b0; din_valid = 1'b0; addr_mode = 1'b0;
    sel_ext = 3'd0; q_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_q_valid", 8'(q_valid), 8'h00);
    chk("rst_sel_cur", 8'(sel_cur), 8'h00);
    chk("rst_din_ready", 8'(din_ready), 8'h01);
    tick();

    // 1: auto basic, bits 1,0,1,1,0,0,1,0 -> 8'h4D
    pat = 8'h4D;
    sb.push_back(8'h4D);
    for (int i = 0; i < 8; i++) begin
      chk("t1_sel_cur", 8'(sel_cur), 8'(i));
      if (i < 7) chk("t1_no_valid", 8'(q_valid), 8'h00);
      send(pat[i], 3'd0);
    end
    chk("t1_q_valid", 8'(q_valid), 8'h01);
    chk("t1_q", q, 8'h4D);
    chk("t1_sel_wrap", 8'(sel_cur), 8'h00);
    tick();
    chk("t1_q_valid_1cyc", 8'(q_valid), 8'h00);

    // 2: backpressure, FF then 0F with q_ready low
    q_ready = 1'b0;
    sb.push_back(8'hFF);
    sb.push_back(8'h0F);
    for (int i = 0; i < 8; i++) send(1'b1, 3'd0);
    chk("t2_q_valid", 8'(q_valid), 8'h01);
    chk("t2_q_ff", q, 8'hFF);
    pat = 8'h0F;
    for (int i = 0; i < 7; i++) send(pat[i], 3'd0);
    din = pat[7]; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall", 8'(din_ready), 8'h00);
      chk("t2_q_held", q, 8'hFF);
      tick();
    end
    q_ready = 1'b1;
    @(negedge clk);
    chk("t2_release", 8'(din_ready), 8'h01);
    tick();
    din_valid = 1'b0;
    chk("t2_q_0f", q, 8'h0F);
    chk("t2_q_valid2", 8'(q_valid), 8'h01);
    tick();

    // 3: addressed mode, slots 7..0 with 1,0,1,0,0,1,0,1 -> 8'hA5
    addr_mode = 1'b1;
    @(negedge clk);
    chk("t3_modechg_ready", 8'(din_ready), 8'h00);
    tick();
    pat = 8'hA5;
    sb.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) send(pat[i], 3'(i));
    chk("t3_q", q, 8'hA5);
    tick();
    // slot 3 written twice (0 then 1): only the 9th accept completes -> 8'hAE
    sb.push_back(8'hAE);
    send(1'b0, 3'd0); send(1'b1, 3'd1); send(1'b1, 3'd2); send(1'b0, 3'd3);
    send(1'b0, 3'd4); send(1'b1, 3'd5); send(1'b1, 3'd3); send(1'b0, 3'd6);
    chk("t3_overwrite_no_complete", 8'(q_valid), 8'h00);
    send(1'b1, 3'd7);
    chk("t3_q_valid9", 8'(q_valid), 8'h01);
    chk("t3_q_ae", q, 8'hAE);
    tick();

    // 4: mode switch discards partial word
    addr_mode = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send(1'b1, 3'd0);
    chk("t4_sel_cur5", 8'(sel_cur), 8'h05);
    addr_mode = 1'b1; din = 1'b1; din_valid = 1'b1; sel_ext = 3'd5;
    @(negedge clk);
    chk("t4_modechg_ready", 8'(din_ready), 8'h00);
    tick();
    din_valid = 1'b0;
    chk("t4_sel_cur_clr", 8'(sel_cur), 8'h00);
    chk("t4_no_valid", 8'(q_valid), 8'h00);
    sb.push_back(8'hAA);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] s;
      s = 3'(k + 5);
      send(s[0], s);
      if (k < 7) chk("t4_partial", 8'(q_valid), 8'h00);
    end
    chk("t4_q_valid", 8'(q_valid), 8'h01);
    chk("t4_q", q, 8'hAA);
    tick();

    // 5: reset mid-word
    addr_mode = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send(1'b1, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_q_valid", 8'(q_valid), 8'h00);
    chk("t5_q", q, 8'h00);
    chk("t5_sel_cur", 8'(sel_cur), 8'h00);
    pat = 8'h06;
    sb.push_back(8'h06);
    for (int i = 0; i < 8; i++) begin
      send(pat[i], 3'd0);
      if (i < 7) chk("t5_partial", 8'(q_valid), 8'h00);
    end
    chk("t5_q_06", q, 8'h06);
    tick();

    // 6: back-to-back, 24 bits with q_ready high
    w = 8'h00;
    for (int k = 0; k < 24; k++) begin
      b = 1'($urandom_range(1, 0));
      w[k % 8] = b;
      if (k % 8 == 7) sb.push_back(w);
      send(b, 3'd0);
      chk("t6_q_valid", 8'(q_valid), 8'((k % 8) == 7));
      if (k % 8 == 7) chk("t6_q", q, w);
    end
    tick();
    tick();
    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
